// File: rtl/packet_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : packet_scheduler_pkg
// Purpose  : Shared types and constants for the two-channel packet scheduler.
//            Holds the scheduler FSM state type, the beat payload field
//            offsets, and the default stream data width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package packet_scheduler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Beat payload layout inside tdata
  localparam int SEQ_LSB    = 0;    // 64-bit packet sequence number
  localparam int BEAT_LSB   = 64;   // 8-bit beat index within the packet
  localparam int CH_BIT     = 72;   // owning channel
  localparam int DW_DEFAULT = 512;  // default stream width (multiple of 128)
  localparam int NUM_CH     = 2;

endpackage : packet_scheduler_pkg
`default_nettype wire

// File: rtl/packet_scheduler_chan_ctr.sv
`default_nettype none
// ============================================================================
// Module   : pkt_chan_ctr
// Purpose  : Per-channel packet bookkeeping: remaining packet count, packets
//            completed since the last accepted start, and the busy flag.
// Ports    : clk      - clock, rising edge
//            resetn   - synchronous active-low reset
//            start_i  - start pulse; accepted only while not busy
//            count_i  - packets to send, sampled on an accepted start
//            done_i   - one packet of this channel completed (tlast handshake)
//            busy_o   - packets outstanding
//            sent_o   - packets completed since the last accepted start
// Revision : 1.0 - initial release
// ============================================================================
module pkt_chan_ctr (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [63:0] count_i,
  input  logic        done_i,
  output logic        busy_o,
  output logic [63:0] sent_o
);

  logic [63:0] rem_q;
  logic [63:0] sent_q;
  logic        busy_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q  <= '0;
      sent_q <= '0;
      busy_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      rem_q  <= count_i;
      sent_q <= '0;
      busy_q <= (count_i != 64'd0);
    end else if (done_i && busy_q) begin
      // start and done cannot coincide: done only occurs while busy,
      // and a start while busy is ignored.
      rem_q  <= rem_q - 64'd1;
      sent_q <= sent_q + 64'd1;
      busy_q <= (rem_q != 64'd1);
    end
  end

  assign busy_o = busy_q;
  assign sent_o = sent_q;

endmodule : pkt_chan_ctr
`default_nettype wire

// File: rtl/packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : packet_scheduler
// Purpose  : Two-channel AXI-Stream packet generator. Each channel is armed
//            with a packet count; packets are granted round-robin and sent
//            as packet_length beats carrying sequence number, beat index and
//            channel in tdata.
// Ports    : clk, resetn             - clock / synchronous active-low reset
//            ch0_count, ch1_count    - packets per channel (sampled on start)
//            packet_length           - beats per packet (0 treated as 1)
//            ch0_start, ch1_start    - one-cycle start pulses
//            m_axis_tdata/tvalid/tlast/tdest/tready - AXI-Stream master
//            ch0_busy, ch1_busy      - channel has packets outstanding
//            ch0_sent, ch1_sent      - packets completed since last start
// Revision : 1.0 - initial release
// ============================================================================
module packet_scheduler
  import packet_scheduler_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [63:0]   ch0_count,
  input  logic [63:0]   ch1_count,
  input  logic [7:0]    packet_length,
  input  logic          ch0_start,
  input  logic          ch1_start,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  output logic          m_axis_tdest,
  input  logic          m_axis_tready,
  output logic          ch0_busy,
  output logic          ch1_busy,
  output logic [63:0]   ch0_sent,
  output logic [63:0]   ch1_sent
);

  logic [NUM_CH-1:0] start_w;
  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] done_w;
  logic [63:0]       count_w [NUM_CH];
  logic [63:0]       sent_w  [NUM_CH];

  assign start_w    = {ch1_start, ch0_start};
  assign count_w[0] = ch0_count;
  assign count_w[1] = ch1_count;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    pkt_chan_ctr u_ctr (
      .clk     (clk),
      .resetn  (resetn),
      .start_i (start_w[i]),
      .count_i (count_w[i]),
      .done_i  (done_w[i]),
      .busy_o  (busy_w[i]),
      .sent_o  (sent_w[i])
    );
  end

  state_e      state_q, state_d;
  logic        grant_q, grant_d;   // channel owning the current packet
  logic        prio_q,  prio_d;    // channel that wins when both are busy
  logic [7:0]  len_q,   len_d;
  logic [7:0]  beat_q,  beat_d;
  logic [63:0] seq_q,   seq_d;
  logic        grant_sel_w;
  logic        last_beat_w;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      len_q   <= 8'd1;
      beat_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      seq_q   <= seq_d;
    end
  end

  // len_q is never 0, so len_q-1 cannot underflow
  assign last_beat_w = (beat_q == (len_q - 8'd1));

  // Both busy: round-robin pointer decides; otherwise the sole busy channel
  assign grant_sel_w = (busy_w[0] && busy_w[1]) ? prio_q : busy_w[1];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    len_d   = len_q;
    beat_d  = beat_q;
    seq_d   = seq_q;
    done_w  = '0;
    case (state_q)
      IDLE: begin
        if (|busy_w) begin
          state_d = SEND;
          grant_d = grant_sel_w;
          prio_d  = ~grant_sel_w;
          len_d   = (packet_length == 8'd0) ? 8'd1 : packet_length;
          beat_d  = '0;
          seq_d   = sent_w[grant_sel_w];
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (last_beat_w) begin
            done_w[grant_q] = 1'b1;
            state_d         = IDLE;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = m_axis_tvalid && last_beat_w;
  assign m_axis_tdest  = grant_q;

  always_comb begin
    m_axis_tdata = '0;
    if (state_q == SEND) begin
      m_axis_tdata[SEQ_LSB +: 64] = seq_q;
      m_axis_tdata[BEAT_LSB +: 8] = beat_q;
      m_axis_tdata[CH_BIT]        = grant_q;
    end
  end

  assign ch0_busy = busy_w[0];
  assign ch1_busy = busy_w[1];
  assign ch0_sent = sent_w[0];
  assign ch1_sent = sent_w[1];

endmodule : packet_scheduler
`default_nettype wire
